// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, state encoding and size helpers for the MIPS pipeline
package mips_pkg;

   localparam int REG_IDX_W = 5;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mem_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_t;

   // Anything that is not a known byte/half opcode is handled as a full word.
   function automatic mem_size_t op_size(input logic [5:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
         default:              op_size = SZ_WORD;
      endcase
   endfunction

   function automatic logic is_aligned(input mem_size_t sz, input logic [1:0] lane);
      case (sz)
         SZ_BYTE: is_aligned = 1'b1;
         SZ_HALF: is_aligned = !lane[0];
         default: is_aligned = (lane == 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and extraction/extension for loads
module mem_lane_align
   import mips_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [1:0]  lane,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   mem_size_t   size;
   logic        signed_ld;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign size      = op_size(op);
   assign signed_ld = (op == OP_LB) || (op == OP_LH);

   always_comb begin
      be        = 4'b1111;
      wdata     = store_data;
      load_data = rdata;
      ld_half   = lane[1] ? rdata[31:16] : rdata[15:0];
      case (lane)
         2'd0:    ld_byte = rdata[7:0];
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         default: ld_byte = rdata[31:24];
      endcase
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << lane;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{signed_ld & ld_byte[7]}}, ld_byte};
         end
         SZ_HALF: begin
            be        = lane[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{signed_ld & ld_half[15]}}, ld_half};
         end
         default: begin
            be        = 4'b1111;
            wdata     = store_data;
            load_data = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_wb_unit.sv
// rtl/mem_wb_unit.sv - MIPS memory-access and write-back stage with req/ack data port
module mem_wb_unit
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_valid,
   output logic                 ex_ready,
   input  logic [5:0]           ex_op,
   input  logic                 ex_reg_write,
   input  logic                 ex_mem_read,
   input  logic                 ex_mem_write,
   input  logic [31:0]          ex_result,
   input  logic [31:0]          ex_store_data,
   input  logic [REG_IDX_W-1:0] ex_dest,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [31:0]          mem_addr,
   output logic [3:0]           mem_be,
   output logic [31:0]          mem_wdata,
   input  logic                 mem_ack,
   input  logic [31:0]          mem_rdata,
   output logic                 reg_write,
   output logic [REG_IDX_W-1:0] write_reg,
   output logic [31:0]          write_data,
   output logic                 misalign_err,
   output logic                 bus_err
);

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

   mem_state_t           state_q, state_d;
   logic                 mem_req_q, mem_req_d;
   logic                 mem_we_q, mem_we_d;
   logic [31:0]          mem_addr_q, mem_addr_d;
   logic [3:0]           mem_be_q, mem_be_d;
   logic [31:0]          mem_wdata_q, mem_wdata_d;
   logic [15:0]          timer_q, timer_d;
   logic [5:0]           op_q, op_d;
   logic [1:0]           lane_q, lane_d;
   logic [REG_IDX_W-1:0] dest_q, dest_d;
   logic                 reg_write_q, reg_write_d;
   logic [REG_IDX_W-1:0] write_reg_q, write_reg_d;
   logic [31:0]          write_data_q, write_data_d;
   logic                 misalign_err_q, misalign_err_d;
   logic                 bus_err_q, bus_err_d;

   logic        accept;
   logic        is_mem;
   logic [5:0]  align_op;
   logic [1:0]  align_lane;
   logic [3:0]  align_be;
   logic [31:0] align_wdata;
   logic [31:0] load_data;

   assign ex_ready = (state_q == ST_IDLE);
   assign accept   = ex_valid && ex_ready;
   assign is_mem   = ex_mem_read || ex_mem_write;

   // One aligner serves both phases: live EX fields while idle, latched op/lane during the access.
   assign align_op   = ex_ready ? ex_op : op_q;
   assign align_lane = ex_ready ? ex_result[1:0] : lane_q;

   mem_lane_align u_align (
      .op         (align_op),
      .lane       (align_lane),
      .store_data (ex_store_data),
      .rdata      (mem_rdata),
      .be         (align_be),
      .wdata      (align_wdata),
      .load_data  (load_data)
   );

   always_comb begin
      state_d        = state_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_be_d       = mem_be_q;
      mem_wdata_d    = mem_wdata_q;
      timer_d        = timer_q;
      op_d           = op_q;
      lane_d         = lane_q;
      dest_d         = dest_q;
      reg_write_d    = 1'b0;
      write_reg_d    = write_reg_q;
      write_data_d   = write_data_q;
      misalign_err_d = 1'b0;
      bus_err_d      = 1'b0;

      if (state_q == ST_IDLE) begin
         if (accept) begin
            if (!is_mem) begin
               reg_write_d  = ex_reg_write && (ex_dest != '0);
               write_reg_d  = ex_dest;
               write_data_d = ex_result;
            end else if (!is_aligned(op_size(ex_op), ex_result[1:0])) begin
               misalign_err_d = 1'b1;
            end else begin
               state_d     = ST_ACCESS;
               mem_req_d   = 1'b1;
               mem_we_d    = ex_mem_write;
               mem_addr_d  = {ex_result[31:2], 2'b00};
               mem_be_d    = ex_mem_write ? align_be : 4'b0000;
               mem_wdata_d = ex_mem_write ? align_wdata : 32'd0;
               timer_d     = 16'd0;
               op_d        = ex_op;
               lane_d      = ex_result[1:0];
               dest_d      = ex_dest;
            end
         end
      end else begin
         // An ack arriving on the threshold cycle completes the access normally.
         if (mem_ack) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            if (!mem_we_q) begin
               reg_write_d  = (dest_q != '0);
               write_reg_d  = dest_q;
               write_data_d = load_data;
            end
         end else if (timer_q == TIMER_LAST) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            bus_err_d = 1'b1;
         end else begin
            timer_d = timer_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= 32'd0;
         mem_be_q       <= 4'b0000;
         mem_wdata_q    <= 32'd0;
         timer_q        <= 16'd0;
         op_q           <= 6'd0;
         lane_q         <= 2'd0;
         dest_q         <= '0;
         reg_write_q    <= 1'b0;
         write_reg_q    <= '0;
         write_data_q   <= 32'd0;
         misalign_err_q <= 1'b0;
         bus_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_be_q       <= mem_be_d;
         mem_wdata_q    <= mem_wdata_d;
         timer_q        <= timer_d;
         op_q           <= op_d;
         lane_q         <= lane_d;
         dest_q         <= dest_d;
         reg_write_q    <= reg_write_d;
         write_reg_q    <= write_reg_d;
         write_data_q   <= write_data_d;
         misalign_err_q <= misalign_err_d;
         bus_err_q      <= bus_err_d;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_be       = mem_be_q;
   assign mem_wdata    = mem_wdata_q;
   assign reg_write    = reg_write_q;
   assign write_reg    = write_reg_q;
   assign write_data   = write_data_q;
   assign misalign_err = misalign_err_q;
   assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_wb_unit.sv
// tb/tb_mem_wb_unit.sv - randomized self-checking bench for mem_wb_unit
module tb_mem_wb_unit;
   import mips_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready, ex_reg_write, ex_mem_read, ex_mem_write;
   logic [5:0]  ex_op;
   logic [31:0] ex_result, ex_store_data;
   logic [4:0]  ex_dest;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        reg_write, misalign_err, bus_err;
   logic [4:0]  write_reg;
   logic [31:0] write_data;

   int n_cmp = 0;
   int n_bad = 0;

   mem_wb_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_result(ex_result),
      .ex_store_data(ex_store_data), .ex_dest(ex_dest),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mis;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] ld;
   } exp_t;

   typedef struct {
      logic        mis;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          req_cycles;
      logic        steady;
      logic        rw;
      logic [4:0]  wreg;
      logic [31:0] wdat;
      logic        berr;
      logic        ready_end;
   } obs_t;

   // Reference: access size in bytes, lane arithmetic and masking straight from the ISA rules.
   function automatic exp_t model(input logic [5:0] op, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] sd, input logic [31:0] rdw);
      exp_t        e;
      int          sz, lane;
      logic [31:0] mask, v;
      lane = int'(addr[1:0]);
      if (op == OP_LB || op == OP_LBU || op == OP_SB)      sz = 1;
      else if (op == OP_LH || op == OP_LHU || op == OP_SH) sz = 2;
      else                                                 sz = 4;
      e.mis   = (lane % sz) != 0;
      mask    = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      e.be    = wr ? 4'(((1 << sz) - 1) << lane) : 4'd0;
      e.wdata = (sz == 1) ? {4{sd[7:0]}} : (sz == 2) ? {2{sd[15:0]}} : sd;
      v = (rdw >> (8 * lane)) & mask;
      if ((op == OP_LB || op == OP_LH) && v[8 * sz - 1]) v = v | ~mask;
      e.ld = v;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one memory-type instruction and records what the DUT does; ack_at counts mem_req cycles from 1.
   task automatic mem_txn(input logic [5:0] op, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [4:0] dest, input logic [31:0] rdw,
                          input int ack_at, output obs_t o);
      ex_valid      = 1'b1;
      ex_op         = op;
      ex_mem_read   = rd;
      ex_mem_write  = wr;
      ex_result     = addr;
      ex_store_data = sd;
      ex_dest       = dest;
      ex_reg_write  = 1'($urandom);
      step();
      ex_valid      = 1'b0;
      ex_op         = 6'($urandom);
      ex_store_data = $urandom;
      o.mis        = misalign_err;
      o.req        = mem_req;
      o.we         = mem_we;
      o.addr       = mem_addr;
      o.be         = mem_be;
      o.wdata      = mem_wdata;
      o.steady     = 1'b1;
      o.req_cycles = 0;
      while (mem_req && o.req_cycles < 20) begin
         o.req_cycles++;
         if (ex_ready || mem_addr !== o.addr || mem_be !== o.be || mem_wdata !== o.wdata || mem_we !== o.we)
            o.steady = 1'b0;
         mem_ack   = (o.req_cycles == ack_at);
         mem_rdata = mem_ack ? rdw : $urandom;
         step();
         mem_ack = 1'b0;
      end
      o.rw        = reg_write;
      o.wreg      = write_reg;
      o.wdat      = write_data;
      o.berr      = bus_err;
      o.ready_end = ex_ready;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
      n_cmp++; if ({mem_req, mem_we, mem_be, reg_write, misalign_err, bus_err} !== 9'd0) begin
         n_bad++; $display("FAIL reset_ctl: got %b want 0", {mem_req, mem_we, mem_be, reg_write, misalign_err, bus_err});
      end
      n_cmp++; if ({mem_addr, mem_wdata, write_data, write_reg} !== 101'd0) begin
         n_bad++; $display("FAIL reset_data: addr %h wdata %h wb %h reg %0d want 0", mem_addr, mem_wdata, write_data, write_reg);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_alu();
      ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_op = 6'b001000;
      ex_reg_write = 1'b1; ex_dest = 5'd5; ex_result = 32'h0000_1234;
      step();
      ex_valid = 1'b0;
      n_cmp++; if (reg_write !== 1'b1) begin n_bad++; $display("FAIL alu_we: got %b want 1", reg_write); end
      n_cmp++; if (write_reg !== 5'd5) begin n_bad++; $display("FAIL alu_reg: got %0d want 5", write_reg); end
      n_cmp++; if (write_data !== 32'h1234) begin n_bad++; $display("FAIL alu_data: got %h want 00001234", write_data); end
      step();
      n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL alu_pulse: got %b want 0", reg_write); end
      ex_valid = 1'b1; ex_dest = 5'd0;
      step();
      ex_valid = 1'b0;
      n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL alu_r0: got %b want 0", reg_write); end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  d;
      logic [31:0] r;
      logic        w;
      ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         d = (i % 4 == 0) ? 5'd0 : 5'($urandom);
         r = $urandom;
         w = 1'($urandom);
         ex_dest = d; ex_result = r; ex_reg_write = w;
         step();
         n_cmp++; if (reg_write !== (w && d != 0)) begin n_bad++; $display("FAIL b2b_we[%0d]: got %b want %b", i, reg_write, w && d != 0); end
         n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ex_ready); end
         if (w && d != 0) begin
            n_cmp++; if (write_reg !== d || write_data !== r) begin
               n_bad++; $display("FAIL b2b_wb[%0d]: got r%0d=%h want r%0d=%h", i, write_reg, write_data, d, r);
            end
         end
      end
      ex_valid = 1'b0; ex_reg_write = 1'b1; ex_dest = 5'd7;
      step();
      n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL b2b_novalid: got %b want 0", reg_write); end
   endtask

   task automatic test_load_ext();
      obs_t o;
      mem_txn(OP_LB, 1'b1, 1'b0, 32'h0000_0103, 32'd0, 5'd9, 32'h80FF_0000, 4, o);
      n_cmp++; if (o.addr !== 32'h100 || o.be !== 4'b0000 || o.we !== 1'b0) begin
         n_bad++; $display("FAIL lb_req: got addr %h be %b we %b want 00000100 0000 0", o.addr, o.be, o.we);
      end
      n_cmp++; if (o.req_cycles != 4 || !o.steady) begin
         n_bad++; $display("FAIL lb_busy: got %0d cycles steady %b want 4 1", o.req_cycles, o.steady);
      end
      n_cmp++; if (o.rw !== 1'b1 || o.wreg !== 5'd9 || o.wdat !== 32'hFFFF_FF80) begin
         n_bad++; $display("FAIL lb_wb: got we %b r%0d=%h want 1 r9=ffffff80", o.rw, o.wreg, o.wdat);
      end
      step();
      mem_txn(OP_LBU, 1'b1, 1'b0, 32'h0000_0103, 32'd0, 5'd9, 32'h80FF_0000, 4, o);
      n_cmp++; if (o.rw !== 1'b1 || o.wdat !== 32'h0000_0080) begin
         n_bad++; $display("FAIL lbu_wb: got we %b data %h want 1 00000080", o.rw, o.wdat);
      end
      step();
   endtask

   task automatic test_store_half();
      obs_t o;
      mem_txn(OP_SH, 1'b0, 1'b1, 32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 32'h1111_1111, 2, o);
      n_cmp++; if (o.we !== 1'b1 || o.be !== 4'b1100 || o.wdata !== 32'hBEEF_BEEF || o.addr !== 32'h200) begin
         n_bad++; $display("FAIL sh_req: got we %b be %b wdata %h addr %h want 1 1100 beefbeef 00000200", o.we, o.be, o.wdata, o.addr);
      end
      n_cmp++; if (o.rw !== 1'b0 || o.ready_end !== 1'b1) begin
         n_bad++; $display("FAIL sh_done: got we %b ready %b want 0 1", o.rw, o.ready_end);
      end
      step();
   endtask

   task automatic test_misalign();
      obs_t o;
      mem_txn(OP_LW, 1'b1, 1'b0, 32'h0000_0101, 32'd0, 5'd4, 32'd0, 1, o);
      n_cmp++; if (o.mis !== 1'b1 || o.req !== 1'b0 || o.rw !== 1'b0) begin
         n_bad++; $display("FAIL lw_misalign: got err %b req %b we %b want 1 0 0", o.mis, o.req, o.rw);
      end
      step();
      n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL misalign_pulse: got %b want 0", misalign_err); end
   endtask

   task automatic test_timeout();
      obs_t        o;
      logic [31:0] rdw;
      mem_txn(OP_LW, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 5'd6, 32'd0, 99, o);
      n_cmp++; if (o.req_cycles != TO || o.berr !== 1'b1 || o.rw !== 1'b0) begin
         n_bad++; $display("FAIL timeout: got %0d cycles berr %b we %b want %0d 1 0", o.req_cycles, o.berr, o.rw, TO);
      end
      step();
      n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL berr_pulse: got %b want 0", bus_err); end
      rdw = $urandom;
      mem_txn(OP_LW, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 5'd6, rdw, TO, o);
      n_cmp++; if (o.berr !== 1'b0 || o.rw !== 1'b1 || o.wdat !== rdw) begin
         n_bad++; $display("FAIL ack_at_limit: got berr %b we %b data %h want 0 1 %h", o.berr, o.rw, o.wdat, rdw);
      end
      step();
   endtask

   task automatic test_reset_mid_access();
      ex_valid = 1'b1; ex_op = OP_LW; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
      ex_result = 32'h0000_0080; ex_dest = 5'd12;
      step();
      ex_valid = 1'b0;
      step();
      rst = 1'b0;
      #1;
      n_cmp++; if (mem_req !== 1'b0 || ex_ready !== 1'b1) begin
         n_bad++; $display("FAIL rst_mid: got req %b ready %b want 0 1", mem_req, ex_ready);
      end
      step();
      rst = 1'b1;
      step();
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      step();
      mem_ack = 1'b0;
      n_cmp++; if (reg_write !== 1'b0 || mem_req !== 1'b0 || ex_ready !== 1'b1) begin
         n_bad++; $display("FAIL late_ack: got we %b req %b ready %b want 0 0 1", reg_write, mem_req, ex_ready);
      end
   endtask

   task automatic test_random_mem();
      obs_t        o;
      exp_t        e;
      logic [5:0]  ops [9];
      logic [5:0]  op;
      logic        rd, wr, exp_rw;
      logic [31:0] addr, sd, rdw;
      logic [4:0]  dest;
      int          k, ack_at, exp_cyc;
      ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, 6'b000000};
      for (int i = 0; i < 60; i++) begin
         k  = $urandom_range(0, 8);
         op = ops[k];
         if (k < 5)      begin rd = 1'b1; wr = 1'b0; end
         else if (k < 8) begin rd = 1'($urandom); wr = 1'b1; end
         else            begin rd = 1'($urandom); wr = !rd || 1'($urandom); end
         addr   = $urandom;
         sd     = $urandom;
         rdw    = $urandom;
         dest   = 5'($urandom);
         ack_at = $urandom_range(1, TO + 2);
         e       = model(op, wr, addr, sd, rdw);
         exp_cyc = e.mis ? 0 : ((ack_at <= TO) ? ack_at : TO);
         exp_rw  = !e.mis && !wr && (ack_at <= TO) && (dest != 0);
         mem_txn(op, rd, wr, addr, sd, dest, rdw, ack_at, o);
         n_cmp++; if (o.mis !== e.mis) begin n_bad++; $display("FAIL rnd_mis[%0d]: got %b want %b", i, o.mis, e.mis); end
         n_cmp++; if (o.req_cycles != exp_cyc) begin n_bad++; $display("FAIL rnd_cycles[%0d]: got %0d want %0d", i, o.req_cycles, exp_cyc); end
         if (!e.mis) begin
            n_cmp++; if (o.addr !== {addr[31:2], 2'b00} || o.we !== wr || o.be !== e.be || !o.steady) begin
               n_bad++; $display("FAIL rnd_req[%0d]: got addr %h we %b be %b steady %b want %h %b %b 1",
                                 i, o.addr, o.we, o.be, o.steady, {addr[31:2], 2'b00}, wr, e.be);
            end
            if (wr) begin
               n_cmp++; if (o.wdata !== e.wdata) begin n_bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, o.wdata, e.wdata); end
            end
         end
         n_cmp++; if (o.rw !== exp_rw) begin n_bad++; $display("FAIL rnd_we[%0d]: got %b want %b", i, o.rw, exp_rw); end
         if (exp_rw) begin
            n_cmp++; if (o.wreg !== dest || o.wdat !== e.ld) begin
               n_bad++; $display("FAIL rnd_wb[%0d]: got r%0d=%h want r%0d=%h", i, o.wreg, o.wdat, dest, e.ld);
            end
         end
         n_cmp++; if (o.berr !== (!e.mis && ack_at > TO) || o.ready_end !== 1'b1) begin
            n_bad++; $display("FAIL rnd_end[%0d]: got berr %b ready %b want %b 1", i, o.berr, o.ready_end, !e.mis && ack_at > TO);
         end
         step();
         n_cmp++; if ({reg_write, misalign_err, bus_err} !== 3'b000) begin
            n_bad++; $display("FAIL rnd_pulse[%0d]: got %b want 000", i, {reg_write, misalign_err, bus_err});
         end
      end
   endtask

   initial begin
      rst = 1'b0; ex_valid = 1'b0; ex_op = 6'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      ex_mem_write = 1'b0; ex_result = 32'd0; ex_store_data = 32'd0; ex_dest = 5'd0;
      mem_ack = 1'b0; mem_rdata = 32'd0;
      test_reset();
      test_alu();
      test_back_to_back();
      test_load_ext();
      test_store_half();
      test_misalign();
      test_timeout();
      test_reset_mid_access();
      test_random_mem();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no summary want summary");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_wb_unit.md
Name: mem_wb_unit

Overview:
- Memory-access and write-back stage of the 5-stage MIPS pipeline.
- Accepts one instruction at a time from EX and performs any load/store over a req/ack data-memory handshake, including byte/half lane steering and load extension.
- Drives the register-file write port (reg_write, write_reg, write_data) consumed by the decode stage: this block is the writer, decode is the reader.
- Stalls EX through ex_ready while a memory access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles mem_req may stay high without mem_ack before the access is aborted (1..65535)

Ports:
clk  input  1  clock
rst  input  1  reset
ex_valid  input  1  EX presents an instruction this cycle
ex_ready  output  1  stage can accept; transfer occurs when ex_valid && ex_ready
ex_op  input  6  opcode ins[31:26], selects load/store width and sign
ex_reg_write  input  1  non-memory op writes ex_result to ex_dest
ex_mem_read  input  1  load instruction
ex_mem_write  input  1  store instruction
ex_result  input  32  ALU result: write-back value, or effective address for memory ops
ex_store_data  input  32  rt value for stores
ex_dest  input  5  destination register
mem_req  output  1  memory request, held until mem_ack or timeout
mem_we  output  1  1 = store
mem_addr  output  32  word address {ex_result[31:2],2'b00}
mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
mem_wdata  output  32  lane-steered store data
mem_ack  input  1  one-cycle completion; mem_rdata valid on that cycle
mem_rdata  input  32  read word
reg_write  output  1  register-file write enable, one-cycle pulse
write_reg  output  5  destination register
write_data  output  32  write-back value
misalign_err  output  1  one-cycle pulse on misaligned access
bus_err  output  1  one-cycle pulse on access timeout

Behaviour:
- Reset: all outputs 0 except ex_ready=1; state IDLE; timeout counter 0. Asserting reset mid-access drops mem_req immediately, and no write-back occurs.
- States: IDLE, ACCESS. ex_ready = (state==IDLE).
- IDLE, accept of a non-memory op: next edge drives reg_write=ex_reg_write && ex_dest!=0, write_reg=ex_dest, write_data=ex_result. Latency 1 cycle. Stays in IDLE; back-to-back accepts are allowed every cycle.
- IDLE, accept of a load/store with aligned address: next edge enters ACCESS with mem_req=1 and mem_we/addr/be/wdata registered; timeout counter cleared. reg_write=0 that cycle.
- Alignment rule: LW/SW need addr[1:0]==0; LH/LHU/SH need addr[0]==0; bytes are always aligned.
- IDLE, misaligned access: no request and no write-back. Next edge pulses misalign_err=1. Stays in IDLE.
- ACCESS: outputs to memory are held stable. Counter increments each cycle without mem_ack.
  - On mem_ack: next edge sets mem_req=0 and returns to IDLE. A load also pulses reg_write (suppressed if dest==0) with the extracted data. A store produces no write-back.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: next edge sets mem_req=0, pulses bus_err, no write-back, returns to IDLE.
  - Ack on the same cycle as the timeout threshold: the ack wins.
  - mem_ack seen while in IDLE is ignored.
- Load extraction uses lane = addr[1:0], latched at accept:
  - LW (100011): whole word.
  - LB/LBU (100000/100100): byte lane, sign- or zero-extended to 32.
  - LH/LHU (100001/100101): half at lane {addr[1],0}, sign- or zero-extended.
- Store steering:
  - SW (101011): be=1111, wdata=data.
  - SH (101001): be=0011 or 1100, wdata={2{data[15:0]}}.
  - SB (101000): be=1<<lane, wdata={4{data[7:0]}}.
- An unknown opcode with ex_mem_read or ex_mem_write set is treated as word width.
- ex_mem_read && ex_mem_write both set: treated as store.
- reg_write, misalign_err, bus_err are single-cycle pulses; write_reg/write_data hold their last value between pulses.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB), state encoding, register-index width.
- One sub-module, mem_lane_align: combinational store steering (be/wdata) and load extraction/extension, keyed by op and lane.

Test Plan:
- Reset, then ADDI-style op (ex_reg_write=1, dest=5, result=0x0000_1234) -> next cycle reg_write=1, write_reg=5, write_data=0x1234; same op with dest=0 -> reg_write stays 0.
- LB at addr 0x103, mem_rdata=0x80FF_0000 acked 3 cycles after mem_req -> mem_addr=0x100, mem_be=0000 (read), ex_ready low 4 cycles, then reg_write with 0xFFFF_FF80; the same access as LBU -> 0x0000_0080.
- SH at 0x202, store_data=0xDEAD_BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF; ack -> no reg_write, ex_ready returns next cycle.
- LW at 0x101 -> no mem_req, misalign_err pulse next cycle, no reg_write.
- TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, bus_err pulse, no write-back; repeat with ack on the 4th cycle -> normal write-back, no bus_err.
- Assert rst in ACCESS cycle 2 -> mem_req=0 and ex_ready=1 immediately; a late mem_ack after reset release causes no reg_write.
